// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types: RV32 NOP, FSM encoding and the queued instruction entry.
package fetch_unit_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] RV32_NOP = 32'h00000013;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0] inst;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Purpose: DEPTH-entry prefetch queue of {inst, pc} with synchronous flush.
// Latency: a pushed entry is visible at the head on the cycle after the push.
// Backpressure: none; the caller's credit scheme guarantees no push into a full queue.
module fetch_fifo
   import fetch_unit_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       push,
   input  fetch_entry_t               push_dat,
   input  logic                       pop,
   input  logic                       flush,
   output fetch_entry_t               head_dat,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);

   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   assign head_dat = mem[rd_ptr];

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         // Power-of-two depth lets the pointers wrap naturally.
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   always_ff @(posedge CLK) begin
      if (push && !flush) mem[wr_ptr] <= push_dat;
   end

endmodule

// File: rtl/fetch_unit.sv
// Purpose: sequential instruction fetch with prefetch queue and redirect flush.
// Latency: request to inst_valid is memory latency + 1 cycle.
// Backpressure: requests throttled by queue credits; responses always accepted.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h00000000,
   parameter int          DEPTH    = 4
) (
   input  logic        CLK,
   input  logic        RST,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        redirect,
   input  logic [31:0] redirect_pc
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_t    state, state_nxt;
   logic [XLEN-1:0] fetch_pc, rsp_pc, target_pc;
   logic [CW-1:0]   inflight, inflight_nxt;
   logic [CW-1:0]   drop_cnt, drop_cnt_nxt;
   logic [CW-1:0]   count;
   logic [CW:0]     credits_used;
   logic            fire, push, pop, empty;
   fetch_entry_t    head;

   assign target_pc     = {redirect_pc[XLEN-1:2], 2'b00};
   assign credits_used  = {1'b0, count} + {1'b0, inflight};
   assign mem_req_valid = (state != IDLE) && !redirect && (credits_used < (CW+1)'(DEPTH));
   assign mem_req_addr  = fetch_pc;
   assign fire          = mem_req_valid && mem_req_ready;

   // A response is only kept if no older stream is still being discarded.
   assign push = mem_rsp_valid && (drop_cnt == '0) && !redirect;

   assign empty      = (count == '0);
   assign inst_valid = !empty && !redirect;
   assign pop        = inst_valid && inst_ready;
   assign inst       = empty ? RV32_NOP : head.inst;
   assign inst_pc    = empty ? '0 : head.pc;

   always_comb begin
      inflight_nxt = inflight + CW'(fire) - CW'(mem_rsp_valid);
      drop_cnt_nxt = drop_cnt;
      if (redirect)
         drop_cnt_nxt = inflight - CW'(mem_rsp_valid);
      else if (mem_rsp_valid && (drop_cnt != '0))
         drop_cnt_nxt = drop_cnt - CW'(1);

      state_nxt = state;
      case (state)
         IDLE:    state_nxt = FETCH;
         FETCH:   if (redirect && (drop_cnt_nxt != '0)) state_nxt = DRAIN;
         DRAIN:   if (drop_cnt_nxt == '0) state_nxt = FETCH;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state    <= IDLE;
         fetch_pc <= RESET_PC;
         rsp_pc   <= RESET_PC;
         inflight <= '0;
         drop_cnt <= '0;
      end else begin
         state    <= state_nxt;
         inflight <= inflight_nxt;
         drop_cnt <= drop_cnt_nxt;
         if (redirect) begin
            fetch_pc <= target_pc;
            rsp_pc   <= target_pc;
         end else begin
            if (fire) fetch_pc <= fetch_pc + 32'd4;
            if (push) rsp_pc   <= rsp_pc + 32'd4;
         end
      end
   end

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .CLK      (CLK),
      .RST      (RST),
      .push     (push),
      .push_dat ({mem_rsp_data, rsp_pc}),
      .pop      (pop),
      .flush    (redirect),
      .head_dat (head),
      .count    (count)
   );

   // Credit invariant: every outstanding request owns a queue slot.
   assert property (@(posedge CLK) disable iff (!RST) credits_used <= (CW+1)'(DEPTH));

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit with an in-order, fixed-latency memory model.
module tb_fetch_unit;

   logic        CLK = 1'b0;
   logic        RST;
   logic        mem_req_valid, mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        inst_valid, inst_ready;
   logic [31:0] inst, inst_pc;
   logic        redirect;
   logic [31:0] redirect_pc;

   logic        w_req_valid, w_inst_valid;
   logic [31:0] w_req_addr, w_inst, w_inst_pc;

   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          lat = 1;
   int          fire_cnt = 0;
   logic [31:0] pend_addr [$];
   int          pend_due  [$];
   logic [63:0] exp_q     [$];
   logic [63:0] mon_exp;

   fetch_unit u_dut (
      .CLK(CLK), .RST(RST),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
      .redirect(redirect), .redirect_pc(redirect_pc)
   );

   fetch_unit #(.RESET_PC(32'hFFFFFFF8), .DEPTH(4)) u_wrap (
      .CLK(CLK), .RST(RST),
      .mem_req_valid(w_req_valid), .mem_req_ready(1'b1), .mem_req_addr(w_req_addr),
      .mem_rsp_valid(1'b0), .mem_rsp_data(32'h0),
      .inst_valid(w_inst_valid), .inst_ready(1'b0), .inst(w_inst), .inst_pc(w_inst_pc),
      .redirect(1'b0), .redirect_pc(32'h0)
   );

   initial forever #5 CLK = ~CLK;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hDEAD0013;
   endfunction

   // Memory: drive responses at negedge, capture accepted requests just before posedge.
   initial begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      forever begin
         @(negedge CLK);
         cyc++;
         if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mem_word(pend_addr[0]);
            pend_addr.delete(0);
            pend_due.delete(0);
         end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = '0;
         end
         #4;
         if (RST && mem_req_valid && mem_req_ready) begin
            pend_addr.push_back(mem_req_addr);
            pend_due.push_back(cyc + lat);
            exp_q.push_back({mem_word(mem_req_addr), mem_req_addr});
            fire_cnt++;
         end
      end
   end

   // Scoreboard: every consumed instruction must match the oldest surviving request.
   initial forever begin
      @(negedge CLK);
      #2;
      if (RST && inst_valid && inst_ready) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL pop_unexpected: got inst=%h pc=%h, required no instruction", inst, inst_pc);
         end else begin
            mon_exp = exp_q.pop_front();
            if ({inst, inst_pc} !== mon_exp) begin
               n_err++;
               $display("FAIL pop_order: got inst=%h pc=%h, required inst=%h pc=%h",
                        inst, inst_pc, mon_exp[63:32], mon_exp[31:0]);
            end
         end
      end
   end

   task automatic step();
      @(negedge CLK);
      #1;
   endtask

   task automatic reset_dut(input int latency);
      step();
      RST = 1'b0;
      redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0; mem_req_ready = 1'b0;
      lat = latency;
      pend_addr.delete(); pend_due.delete(); exp_q.delete();
      repeat (2) @(negedge CLK);
      #1;
      RST = 1'b1;
      fire_cnt = 0;
   endtask

   task automatic test_reset();
      RST = 1'b0; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0; mem_req_ready = 1'b0;
      #1;
      n_vec++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL rst_req_valid: got %b, required 0", mem_req_valid); end
      n_vec++; if (mem_req_addr !== 32'h0) begin n_err++; $display("FAIL rst_req_addr: got %h, required 00000000", mem_req_addr); end
      n_vec++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rst_inst_valid: got %b, required 0", inst_valid); end
      n_vec++; if (inst !== 32'h00000013) begin n_err++; $display("FAIL rst_inst: got %h, required 00000013", inst); end
      n_vec++; if (inst_pc !== 32'h0) begin n_err++; $display("FAIL rst_inst_pc: got %h, required 00000000", inst_pc); end
   endtask

   task automatic test_stream();
      reset_dut(1);
      mem_req_ready = 1'b1; inst_ready = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step(); #1;
         n_vec++;
         if (!(mem_req_valid === 1'b1 && mem_req_addr === 32'(4*(k-1)))) begin
            n_err++; $display("FAIL stream_req[%0d]: got v=%b a=%h, required v=1 a=%h", k, mem_req_valid, mem_req_addr, 32'(4*(k-1)));
         end
         n_vec++;
         if (inst_valid !== ((k >= 3) ? 1'b1 : 1'b0)) begin
            n_err++; $display("FAIL stream_valid[%0d]: got %b, required %b", k, inst_valid, (k >= 3));
         end
         if (k >= 3) begin
            n_vec++;
            if (inst_pc !== 32'(4*(k-3))) begin
               n_err++; $display("FAIL stream_pc[%0d]: got %h, required %h", k, inst_pc, 32'(4*(k-3)));
            end
         end
      end
   endtask

   task automatic test_backpressure();
      reset_dut(1);
      mem_req_ready = 1'b1;
      repeat (8) step();
      #1;
      n_vec++; if (fire_cnt != 4) begin n_err++; $display("FAIL bp_fires: got %0d, required 4", fire_cnt); end
      n_vec++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL bp_req_stop: got %b, required 0", mem_req_valid); end
      n_vec++; if (!(inst_valid === 1'b1 && inst_pc === 32'h0)) begin n_err++; $display("FAIL bp_head: got v=%b pc=%h, required v=1 pc=0", inst_valid, inst_pc); end
      step(); inst_ready = 1'b1; #1;
      n_vec++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL bp_pop_cycle_req: got %b, required 0", mem_req_valid); end
      step(); #1;
      n_vec++;
      if (!(mem_req_valid === 1'b1 && mem_req_addr === 32'h10)) begin
         n_err++; $display("FAIL bp_credit_req: got v=%b a=%h, required v=1 a=00000010", mem_req_valid, mem_req_addr);
      end
      repeat (6) step();
   endtask

   task automatic test_req_stall();
      reset_dut(1);
      mem_req_ready = 1'b1; inst_ready = 1'b1;
      step(); step();
      for (int k = 0; k < 3; k++) begin
         step(); mem_req_ready = 1'b0; #1;
         n_vec++;
         if (!(mem_req_valid === 1'b1 && mem_req_addr === 32'h8)) begin
            n_err++; $display("FAIL stall_hold[%0d]: got v=%b a=%h, required v=1 a=00000008", k, mem_req_valid, mem_req_addr);
         end
      end
      step(); mem_req_ready = 1'b1; #1;
      n_vec++; if (!(mem_req_valid === 1'b1 && mem_req_addr === 32'h8)) begin n_err++; $display("FAIL stall_fire: got v=%b a=%h, required v=1 a=00000008", mem_req_valid, mem_req_addr); end
      step(); #1;
      n_vec++; if (mem_req_addr !== 32'hC) begin n_err++; $display("FAIL stall_next: got %h, required 0000000c", mem_req_addr); end
      repeat (4) step();
   endtask

   task automatic test_redirect();
      reset_dut(3);
      mem_req_ready = 1'b1; inst_ready = 1'b1;
      step(); step();
      step(); redirect = 1'b1; redirect_pc = 32'h103; exp_q.delete(); #1;
      n_vec++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL redir_req_blocked: got %b, required 0", mem_req_valid); end
      step(); redirect = 1'b0; #1;
      n_vec++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL redir_flush: got %b, required 0", inst_valid); end
      n_vec++;
      if (!(mem_req_valid === 1'b1 && mem_req_addr === 32'h100)) begin
         n_err++; $display("FAIL redir_first_req: got v=%b a=%h, required v=1 a=00000100", mem_req_valid, mem_req_addr);
      end
      for (int k = 0; k < 3; k++) begin
         step(); #1;
         n_vec++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL redir_drop[%0d]: got v=%b pc=%h, required v=0", k, inst_valid, inst_pc); end
      end
      step(); #1;
      n_vec++;
      if (!(inst_valid === 1'b1 && inst_pc === 32'h100 && inst === mem_word(32'h100))) begin
         n_err++; $display("FAIL redir_target: got v=%b pc=%h inst=%h, required v=1 pc=00000100 inst=%h", inst_valid, inst_pc, inst, mem_word(32'h100));
      end
      repeat (4) step();
   endtask

   task automatic test_redirect_rsp();
      reset_dut(2);
      mem_req_ready = 1'b1; inst_ready = 1'b1;
      step(); step();
      step(); redirect = 1'b1; redirect_pc = 32'h200; exp_q.delete(); #1;
      n_vec++; if (mem_rsp_valid !== 1'b1) begin n_err++; $display("FAIL rr_setup_rsp: got %b, required 1", mem_rsp_valid); end
      step(); redirect = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (k != 0) step();
         #1;
         n_vec++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rr_drop[%0d]: got v=%b pc=%h, required v=0", k, inst_valid, inst_pc); end
      end
      step(); #1;
      n_vec++; if (!(inst_valid === 1'b1 && inst_pc === 32'h200)) begin n_err++; $display("FAIL rr_accept: got v=%b pc=%h, required v=1 pc=00000200", inst_valid, inst_pc); end
      step(); #1;
      n_vec++; if (!(inst_valid === 1'b1 && inst_pc === 32'h204)) begin n_err++; $display("FAIL rr_next: got v=%b pc=%h, required v=1 pc=00000204", inst_valid, inst_pc); end
      repeat (3) step();
   endtask

   task automatic test_wrap();
      logic [31:0] wexp [3];
      wexp[0] = 32'hFFFFFFF8; wexp[1] = 32'hFFFFFFFC; wexp[2] = 32'h00000000;
      reset_dut(1);
      for (int k = 0; k < 3; k++) begin
         step(); #1;
         n_vec++;
         if (!(w_req_valid === 1'b1 && w_req_addr === wexp[k])) begin
            n_err++; $display("FAIL wrap_addr[%0d]: got v=%b a=%h, required v=1 a=%h", k, w_req_valid, w_req_addr, wexp[k]);
         end
      end
   endtask

   task automatic test_reset_mid();
      reset_dut(1);
      mem_req_ready = 1'b1; inst_ready = 1'b1;
      repeat (5) step();
      #1;
      n_vec++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre_valid: got %b, required 1", inst_valid); end
      #1; RST = 1'b0; #1;
      n_vec++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL mid_req_valid: got %b, required 0", mem_req_valid); end
      n_vec++; if (mem_req_addr !== 32'h0) begin n_err++; $display("FAIL mid_req_addr: got %h, required 00000000", mem_req_addr); end
      n_vec++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL mid_inst_valid: got %b, required 0", inst_valid); end
      n_vec++; if (inst !== 32'h00000013) begin n_err++; $display("FAIL mid_inst: got %h, required 00000013", inst); end
      n_vec++; if (inst_pc !== 32'h0) begin n_err++; $display("FAIL mid_inst_pc: got %h, required 00000000", inst_pc); end
      pend_addr.delete(); pend_due.delete(); exp_q.delete();
      reset_dut(1);
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_req_stall();
      test_redirect();
      test_redirect_rsp();
      test_wrap();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
